// File: rtl/uart_tx_pkg.sv
// Definitions shared by the UART transmit path: the arbiter FSM states and the
// baud/frame timing derived from clock and line rate.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10
  } txState_e;

  localparam int unsigned DEF_UART_BPS = 921600;
  localparam int unsigned DEF_CLK_FREQ = 20_000_000;
  localparam int unsigned FRAME_CNT_W  = 16;

  function automatic int unsigned baudCntMax(input int unsigned clkFreq,
                                             input int unsigned uartBps);
    return clkFreq / uartBps + 1;
  endfunction

  // Ten bit times on the wire plus one bit of margin before the next start pulse.
  function automatic int unsigned frameCycles(input int unsigned clkFreq,
                                              input int unsigned uartBps);
    return 11 * baudCntMax(clkFreq, uartBps);
  endfunction

  localparam int unsigned BAUD_CNT_MAX = baudCntMax(DEF_CLK_FREQ, DEF_UART_BPS);
  localparam int unsigned FRAME_CYCLES = frameCycles(DEF_CLK_FREQ, DEF_UART_BPS);

endpackage

// File: rtl/uart_frame_timer.sv
// Counts out one transmitter frame: cleared by start, then runs from 0 and
// raises done on its final count before stopping.
module uart_frame_timer
  import uart_tx_pkg::FRAME_CNT_W;
#(
  parameter int unsigned FRAME_CYCLES = uart_tx_pkg::FRAME_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic start,
  output logic done
);

  if (FRAME_CYCLES == 0 || FRAME_CYCLES > (2 ** FRAME_CNT_W) - 1) begin : gBadFrame
    $error("uart_frame_timer: FRAME_CYCLES %0d does not fit the frame counter", FRAME_CYCLES);
  end

  localparam logic [FRAME_CNT_W-1:0] LAST_COUNT = FRAME_CNT_W'(FRAME_CYCLES - 1);

  logic [FRAME_CNT_W-1:0] count_q, count_d;
  logic                   running_q, running_d;

  always_comb begin
    count_d   = count_q;
    running_d = running_q;
    done      = running_q && (count_q == LAST_COUNT);
    if (start) begin
      count_d   = '0;
      running_d = 1'b1;
    end else if (done) begin
      count_d   = '0;
      running_d = 1'b0;
    end else if (running_q) begin
      count_d = count_q + FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the SD read stream and the status log,
// granting whole packets round-robin and pacing bytes to the frame time.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int unsigned UART_BPS = DEF_UART_BPS,
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       tx_flag,
  output logic       busy,
  output logic       owner
);

  localparam int unsigned FRAME_LEN = frameCycles(CLK_FREQ, UART_BPS);

  txState_e   state_q, state_d;
  logic [7:0] txData_q, txData_d;
  logic       owner_q, owner_d;
  logic       rrPtr_q, rrPtr_d;
  logic       lock_q, lock_d;

  logic       grant;
  logic       sel;
  logic       selLast;
  logic [7:0] selData;
  logic       timerStart;
  logic       timerDone;

  uart_frame_timer #(
    .FRAME_CYCLES(FRAME_LEN)
  ) uFrameTimer (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (timerStart),
    .done     (timerDone)
  );

  // A locked packet keeps the line until its last byte, even if its owner
  // stalls; otherwise a lone requester wins and a tie goes to rrPtr.
  always_comb begin
    state_d    = state_q;
    txData_d   = txData_q;
    owner_d    = owner_q;
    rrPtr_d    = rrPtr_q;
    lock_d     = lock_q;
    grant      = 1'b0;
    sel        = rrPtr_q;
    tx_flag    = 1'b0;
    timerStart = 1'b0;

    if (state_q == IDLE && sys_rst_n) begin
      if (lock_q) begin
        sel   = owner_q;
        grant = owner_q ? s1_valid : s0_valid;
      end else if (s0_valid && s1_valid) begin
        sel   = rrPtr_q;
        grant = 1'b1;
      end else if (s0_valid) begin
        sel   = 1'b0;
        grant = 1'b1;
      end else if (s1_valid) begin
        sel   = 1'b1;
        grant = 1'b1;
      end
    end

    selData  = sel ? s1_data : s0_data;
    selLast  = sel ? s1_last : s0_last;
    s0_ready = grant && !sel;
    s1_ready = grant && sel;

    case (state_q)
      IDLE: begin
        if (grant) begin
          txData_d = selData;
          owner_d  = sel;
          lock_d   = !selLast;
          if (selLast) begin
            rrPtr_d = !sel;
          end
          state_d = START;
        end
      end
      START: begin
        tx_flag    = 1'b1;
        timerStart = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (timerDone) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      txData_q <= 8'h00;
      owner_q  <= 1'b0;
      rrPtr_q  <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      txData_q <= txData_d;
      owner_q  <= owner_d;
      rrPtr_q  <= rrPtr_d;
      lock_q   <= lock_d;
    end
  end

  assign tx_data = txData_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);

endmodule
